// File: rtl/mux_pkg.sv
// Shared helpers for the selecting-mux pipeline: select-width sizing and
// the storage width of the out-of-range default value.
package mux_pkg;

    localparam int DEFAULT_W = 32;

    // Never narrower than one bit, so a 2:1 mux still has a real select.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/skid_buffer.sv
// One-entry valid/ready skid buffer with a registered ready, so upstream
// never sees a combinational path from out_ready.
module skid_buffer #(
    parameter int DATA_W = 33
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    logic              accept;
    logic              load;
    logic              skid_full;
    logic              skid_full_nxt;
    logic [DATA_W-1:0] skid_data;

    always_comb begin
        accept        = in_valid & in_ready;
        load          = !out_valid | out_ready;
        skid_full_nxt = skid_full;
        if (load) begin
            if (skid_full) skid_full_nxt = accept;
        end else if (accept) begin
            skid_full_nxt = 1'b1;
        end
    end

    // Output stage: the skid always drains ahead of any new beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            skid_full <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            skid_full <= skid_full_nxt;
            in_ready  <= !skid_full_nxt;
            if (load) begin
                out_valid <= skid_full | accept;
                if (skid_full)   out_data <= skid_data;
                else if (accept) out_data <= in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && (!load || skid_full)) skid_data <= in_data;
    end

endmodule

// File: rtl/mux_n_pipe.sv
// N-input selecting mux registered behind a skid buffer; out-of-range
// selects produce DEFAULT_VALUE plus per-beat and sticky error flags.
module mux_n_pipe
    import mux_pkg::*;
#(
    parameter int                   WIDTH         = 32,
    parameter int                   N             = 3,
    parameter logic [DEFAULT_W-1:0] DEFAULT_VALUE = '0,
    localparam int                  SEL_W         = sel_width(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_err,
    output logic               err_sticky,
    input  logic               err_clear
);

    logic             accept;
    logic [WIDTH-1:0] sel_data_p0;
    logic             sel_err_p0;
    logic [WIDTH:0]   out_word;

    assign accept = in_valid & in_ready;

    // Any select value that matches no input falls through to the default.
    always_comb begin
        sel_data_p0 = WIDTH'(DEFAULT_VALUE);
        sel_err_p0  = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_data_p0 = in_data[k*WIDTH +: WIDTH];
                sel_err_p0  = 1'b0;
            end
        end
    end

    // Stage p0 -> p1: selection and its error bit travel together.
    skid_buffer #(
        .DATA_W (WIDTH + 1)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   ({sel_err_p0, sel_data_p0}),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_word),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    assign out_data = out_word[WIDTH-1:0];
    assign out_err  = out_word[WIDTH];

    // Setting beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     err_sticky <= 1'b0;
        else if (accept && sel_err_p0)  err_sticky <= 1'b1;
        else if (err_clear)             err_sticky <= 1'b0;
    end

endmodule

// File: tb/tb_mux_n_pipe.sv
// Directed bench for mux_n_pipe: a 3:1 32-bit instance for handshake,
// error and reset cases, plus 2/5/16-input 8-bit instances on random traffic.
module tb_mux_n_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Main 3:1, 32-bit instance
    logic [95:0] m_data;
    logic [1:0]  m_sel;
    logic        m_valid, m_in_ready, m_out_valid, m_out_ready;
    logic [31:0] m_out_data;
    logic        m_out_err, m_sticky, m_clear;

    mux_n_pipe #(.WIDTH(32), .N(3)) u_main (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (m_data),
        .in_sel     (m_sel),
        .in_valid   (m_valid),
        .in_ready   (m_in_ready),
        .out_data   (m_out_data),
        .out_valid  (m_out_valid),
        .out_ready  (m_out_ready),
        .out_err    (m_out_err),
        .err_sticky (m_sticky),
        .err_clear  (m_clear)
    );

    // Sweep instances: N = 2, 5, 16 at WIDTH = 8
    logic [127:0] sw_data   [3];
    logic [3:0]   sw_sel    [3];
    logic         sw_valid  [3];
    logic         sw_in_rdy [3];
    logic [7:0]   sw_odata  [3];
    logic         sw_ovld   [3];
    logic         sw_ordy   [3];
    logic         sw_oerr   [3];
    logic         sw_sticky [3];
    logic         sw_clear  [3];

    for (genvar g = 0; g < 3; g++) begin : g_sw
        localparam int GN = (g == 0) ? 2 : (g == 1) ? 5 : 16;
        localparam int GB = (g == 0) ? 1 : (g == 1) ? 3 : 4;
        localparam logic [31:0] GD = (g == 1) ? 32'h1A5 : 32'h0;
        mux_n_pipe #(.WIDTH(8), .N(GN), .DEFAULT_VALUE(GD)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .in_data    (sw_data[g][GN*8-1:0]),
            .in_sel     (sw_sel[g][GB-1:0]),
            .in_valid   (sw_valid[g]),
            .in_ready   (sw_in_rdy[g]),
            .out_data   (sw_odata[g]),
            .out_valid  (sw_ovld[g]),
            .out_ready  (sw_ordy[g]),
            .out_err    (sw_oerr[g]),
            .err_sticky (sw_sticky[g]),
            .err_clear  (sw_clear[g])
        );
    end

    function automatic int sw_n(input int g);
        return (g == 0) ? 2 : (g == 1) ? 5 : 16;
    endfunction

    function automatic int sw_bits(input int g);
        return (g == 0) ? 1 : (g == 1) ? 3 : 4;
    endfunction

    // DEFAULT_VALUE 0x1A5 truncated to 8 bits is 0xA5
    function automatic logic [7:0] sw_dflt(input int g);
        return (g == 1) ? 8'hA5 : 8'h00;
    endfunction

    logic [8:0] sb [3][64];
    int         wr [3];
    int         rd [3];
    logic       any_err [3];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just before the edge: records beats that this edge transfers.
    task automatic sweep_observe();
        int s;
        logic [8:0] e;
        for (int g = 0; g < 3; g++) begin
            if (sw_ovld[g] && sw_ordy[g]) begin
                check("sw_pending", 64'(wr[g] != rd[g]), 64'd1);
                if (wr[g] != rd[g]) begin
                    check("sw_beat", {55'd0, sw_oerr[g], sw_odata[g]}, {55'd0, sb[g][rd[g] % 64]});
                    rd[g]++;
                end
            end
            if (sw_valid[g] && sw_in_rdy[g]) begin
                s = int'(sw_sel[g]);
                if (s < sw_n(g)) e = {1'b0, sw_data[g][s*8 +: 8]};
                else             e = {1'b1, sw_dflt(g)};
                if (e[8]) any_err[g] = 1'b1;
                sb[g][wr[g] % 64] = e;
                wr[g]++;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        m_data = {32'hC, 32'hB, 32'hA};
        m_sel = 2'd0;
        m_valid = 1'b0;
        m_out_ready = 1'b1;
        m_clear = 1'b0;
        for (int g = 0; g < 3; g++) begin
            sw_data[g] = '0;
            sw_sel[g] = '0;
            sw_valid[g] = 1'b0;
            sw_ordy[g] = 1'b1;
            sw_clear[g] = 1'b0;
            wr[g] = 0;
            rd[g] = 0;
            any_err[g] = 1'b0;
        end

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(m_out_valid), 64'd0);
        check("rst_out_data", 64'(m_out_data), 64'd0);
        check("rst_out_err", 64'(m_out_err), 64'd0);
        check("rst_in_ready", 64'(m_in_ready), 64'd1);
        check("rst_sticky", 64'(m_sticky), 64'd0);
        rst_n = 1'b1;

        // Back-to-back selects with out_ready high
        @(negedge clk);
        m_valid = 1'b1; m_sel = 2'd0;
        @(negedge clk);
        check("sel0_data", 64'(m_out_data), 64'hA);
        check("sel0_valid", 64'(m_out_valid), 64'd1);
        check("sel0_err", 64'(m_out_err), 64'd0);
        m_sel = 2'd1;
        @(negedge clk);
        check("sel1_data", 64'(m_out_data), 64'hB);
        check("sel1_in_ready", 64'(m_in_ready), 64'd1);
        m_sel = 2'd2;
        @(negedge clk);
        check("sel2_data", 64'(m_out_data), 64'hC);
        check("sel2_in_ready", 64'(m_in_ready), 64'd1);
        m_valid = 1'b0;
        @(negedge clk);
        check("idle_valid", 64'(m_out_valid), 64'd0);

        // Out-of-range select, then sticky clear
        m_valid = 1'b1; m_sel = 2'd3;
        @(negedge clk);
        check("oor_data", 64'(m_out_data), 64'd0);
        check("oor_err", 64'(m_out_err), 64'd1);
        check("oor_valid", 64'(m_out_valid), 64'd1);
        check("oor_sticky", 64'(m_sticky), 64'd1);
        m_valid = 1'b0; m_clear = 1'b1;
        @(negedge clk);
        check("clear_sticky", 64'(m_sticky), 64'd0);
        m_clear = 1'b0;

        // Backpressure: first beat held, second beat in the skid
        m_out_ready = 1'b0; m_valid = 1'b1; m_sel = 2'd1;
        @(negedge clk);
        check("bp_first_data", 64'(m_out_data), 64'hB);
        check("bp_first_ready", 64'(m_in_ready), 64'd1);
        m_sel = 2'd2;
        @(negedge clk);
        check("bp_skid_in_ready", 64'(m_in_ready), 64'd0);
        check("bp_hold_data", 64'(m_out_data), 64'hB);
        m_valid = 1'b0;
        @(negedge clk);
        check("bp_hold_data2", 64'(m_out_data), 64'hB);
        check("bp_hold_valid", 64'(m_out_valid), 64'd1);
        check("bp_hold_in_ready", 64'(m_in_ready), 64'd0);
        m_out_ready = 1'b1;
        @(negedge clk);
        check("bp_drain_data", 64'(m_out_data), 64'hC);
        check("bp_drain_valid", 64'(m_out_valid), 64'd1);
        check("bp_drain_in_ready", 64'(m_in_ready), 64'd1);
        @(negedge clk);
        check("bp_empty_valid", 64'(m_out_valid), 64'd0);

        // Clear and new error in the same cycle: set wins
        m_valid = 1'b1; m_sel = 2'd3; m_clear = 1'b1;
        @(negedge clk);
        check("setwin_sticky", 64'(m_sticky), 64'd1);
        check("setwin_err", 64'(m_out_err), 64'd1);
        m_valid = 1'b0; m_clear = 1'b0;
        @(negedge clk);

        // Asynchronous reset with the skid full
        m_out_ready = 1'b0; m_valid = 1'b1; m_sel = 2'd0;
        @(negedge clk);
        check("ar_first_data", 64'(m_out_data), 64'hA);
        m_sel = 2'd1;
        @(negedge clk);
        check("ar_skid_in_ready", 64'(m_in_ready), 64'd0);
        m_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("ar_out_valid", 64'(m_out_valid), 64'd0);
        check("ar_in_ready", 64'(m_in_ready), 64'd1);
        check("ar_sticky", 64'(m_sticky), 64'd0);
        @(negedge clk);
        rst_n = 1'b1; m_out_ready = 1'b1;
        @(negedge clk);
        check("ar_no_stale1", 64'(m_out_valid), 64'd0);
        @(negedge clk);
        check("ar_no_stale2", 64'(m_out_valid), 64'd0);
        check("ar_ready_after", 64'(m_in_ready), 64'd1);

        // Random traffic on the sweep instances
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                sw_valid[g] = ($urandom_range(0, 9) < 7);
                sw_ordy[g]  = ($urandom_range(0, 9) < 6);
                sw_sel[g]   = 4'($urandom_range(0, (1 << sw_bits(g)) - 1));
                sw_data[g]  = {$urandom, $urandom, $urandom, $urandom};
            end
            #1;
            sweep_observe();
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                sw_valid[g] = 1'b0;
                sw_ordy[g] = 1'b1;
            end
            #1;
            sweep_observe();
        end
        for (int g = 0; g < 3; g++) begin
            check("sw_all_delivered", 64'(wr[g] - rd[g]), 64'd0);
            check("sw_drained_valid", 64'(sw_ovld[g]), 64'd0);
            check("sw_sticky", 64'(sw_sticky[g]), 64'(any_err[g]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
